// File: rtl/sub_64_pkg.sv
// ---------------------------------------------------------------------------
// sub_64_pkg
// Shared widths and types for the pipelined 64-bit subtractor.
//   DATA_W   : operand / result width
//   SLICE_W  : width of one pipeline slice
//   N_STAGES : number of slices (one pipeline register stage per slice)
// ---------------------------------------------------------------------------
package sub_64_pkg;

    localparam int DATA_W   = 64;
    localparam int SLICE_W  = 16;
    localparam int N_STAGES = 4;

    typedef logic [DATA_W-1:0]  word_t;
    typedef logic [SLICE_W-1:0] slice_t;

    // Two's-complement overflow of a subtraction, from the sign bits alone:
    // the operands differ in sign and the result's sign differs from a's.
    function automatic logic sub_ovf(input logic a_msb,
                                     input logic b_msb,
                                     input logic d_msb);
        return (a_msb ^ b_msb) & (d_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/sub_64_if.sv
// ---------------------------------------------------------------------------
// sub_64_if
// Valid/ready handshake bundle for the 64-bit subtractor.
//   Input side : in_valid, in_ready, a_in, b_in, borrow_in
//   Output side: out_valid, out_ready, diff_out, borrow_out, ovf_out
// Modports:
//   master : producer/consumer around the subtractor (e.g. a testbench)
//   slave  : the subtractor itself
// ---------------------------------------------------------------------------
interface sub_64_if;
    import sub_64_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t a_in;
    word_t b_in;
    logic  borrow_in;

    logic  out_valid;
    logic  out_ready;
    word_t diff_out;
    logic  borrow_out;
    logic  ovf_out;

    modport master (
        output in_valid, a_in, b_in, borrow_in, out_ready,
        input  in_ready, out_valid, diff_out, borrow_out, ovf_out
    );

    modport slave (
        input  in_valid, a_in, b_in, borrow_in, out_ready,
        output in_ready, out_valid, diff_out, borrow_out, ovf_out
    );

endinterface

// File: rtl/sub_16.sv
// ---------------------------------------------------------------------------
// sub_16
// Combinational 16-bit subtract slice: {borrow_o, diff_o} = a_i - b_i - borrow_i
// Ports:
//   a_i      : minuend slice
//   b_i      : subtrahend slice
//   borrow_i : borrow into the slice LSB
//   diff_o   : difference slice (mod 2^16)
//   borrow_o : borrow out of the slice MSB
// ---------------------------------------------------------------------------
module sub_16
    import sub_64_pkg::*;
(
    input  slice_t a_i,
    input  slice_t b_i,
    input  logic   borrow_i,
    output slice_t diff_o,
    output logic   borrow_o
);

    // One extra bit: a negative result (borrow) lands as a 1 in the top bit.
    logic [SLICE_W:0] wide;

    assign wide     = {1'b0, a_i} - {1'b0, b_i} - {{SLICE_W{1'b0}}, borrow_i};
    assign diff_o   = wide[SLICE_W-1:0];
    assign borrow_o = wide[SLICE_W];

endmodule

// File: rtl/sub_64.sv
// ---------------------------------------------------------------------------
// sub_64
// Four-stage pipelined 64-bit unsigned subtractor with valid/ready handshake.
// Each stage resolves one 16-bit slice; the borrow travels one stage per
// cycle while operand slices are skewed to meet it. All four slices leave
// stage 3 together, 4 cycles after acceptance, one result per cycle.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : sub_64_if.slave (in_valid/in_ready/a_in/b_in/borrow_in,
//           out_valid/out_ready/diff_out/borrow_out/ovf_out)
// ---------------------------------------------------------------------------
module sub_64
    import sub_64_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    sub_64_if.slave  bus
);

    // Per-stage pipeline registers. a_q/b_q carry the full operands; each
    // stage only reads the slice it still needs (plus the sign bits at the
    // end), the rest is dead weight the synthesiser trims away.
    logic  valid_q  [N_STAGES];
    logic  borrow_q [N_STAGES];
    word_t a_q      [N_STAGES];
    word_t b_q      [N_STAGES];
    word_t diff_q   [N_STAGES];

    // Next-state partial differences and slice datapath wiring.
    word_t  diff_d  [N_STAGES];
    slice_t sl_a    [N_STAGES];
    slice_t sl_b    [N_STAGES];
    slice_t sl_diff [N_STAGES];
    logic   sl_bin  [N_STAGES];
    logic   sl_bout [N_STAGES];

    // Single global enable: the whole pipe freezes when the last stage holds
    // a result nobody is taking. No per-stage skid buffering.
    logic stall;
    logic advance;

    assign stall        = valid_q[N_STAGES-1] & ~bus.out_ready;
    assign advance      = ~stall;
    assign bus.in_ready = advance;

    generate
        for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                // Slice 0 works straight off the inputs.
                assign sl_a[gi]   = bus.a_in[SLICE_W-1:0];
                assign sl_b[gi]   = bus.b_in[SLICE_W-1:0];
                assign sl_bin[gi] = bus.borrow_in;
                assign diff_d[gi] = {{(DATA_W-SLICE_W){1'b0}}, sl_diff[gi]};
            end else begin : g_rest
                // Slice gi reads operands that have been delayed gi stages
                // and the borrow registered by the previous stage.
                assign sl_a[gi]   = a_q[gi-1][gi*SLICE_W +: SLICE_W];
                assign sl_b[gi]   = b_q[gi-1][gi*SLICE_W +: SLICE_W];
                assign sl_bin[gi] = borrow_q[gi-1];
                // Bits above the finished low slices are always zero in
                // diff_q (cleared at reset, zero-extended at stage 0), so the
                // new slice can simply be OR'd into its position.
                assign diff_d[gi] = diff_q[gi-1]
                                  | (word_t'(sl_diff[gi]) << (gi*SLICE_W));
            end

            sub_16 u_slice (
                .a_i      (sl_a[gi]),
                .b_i      (sl_b[gi]),
                .borrow_i (sl_bin[gi]),
                .diff_o   (sl_diff[gi]),
                .borrow_o (sl_bout[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < N_STAGES; s++) begin
                valid_q[s]  <= 1'b0;
                borrow_q[s] <= 1'b0;
                a_q[s]      <= '0;
                b_q[s]      <= '0;
                diff_q[s]   <= '0;
            end
        end else if (advance) begin
            // A bubble (in_valid=0) still shifts through; only its valid bit
            // matters downstream.
            valid_q[0] <= bus.in_valid;
            a_q[0]     <= bus.a_in;
            b_q[0]     <= bus.b_in;
            for (int s = 0; s < N_STAGES; s++) begin
                diff_q[s]   <= diff_d[s];
                borrow_q[s] <= sl_bout[s];
            end
            for (int s = 1; s < N_STAGES; s++) begin
                valid_q[s] <= valid_q[s-1];
                a_q[s]     <= a_q[s-1];
                b_q[s]     <= b_q[s-1];
            end
        end
    end

    assign bus.out_valid  = valid_q[N_STAGES-1];
    assign bus.diff_out   = diff_q[N_STAGES-1];
    assign bus.borrow_out = borrow_q[N_STAGES-1];
    assign bus.ovf_out    = sub_ovf(a_q[N_STAGES-1][DATA_W-1],
                                    b_q[N_STAGES-1][DATA_W-1],
                                    diff_q[N_STAGES-1][DATA_W-1]);

endmodule

// File: tb/tb_sub_64.sv
// ---------------------------------------------------------------------------
// tb_sub_64
// Self-checking bench for sub_64: directed corner vectors, back-to-back
// random traffic, a full-pipe stall, reset with transfers in flight, and a
// long randomized valid/ready phase, all scored against an arithmetic model.
// ---------------------------------------------------------------------------
module tb_sub_64;
    import sub_64_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sub_64_if bus ();

    sub_64 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        word_t       diff;
        logic        bout;
        logic        ovf;
        int unsigned acc_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cons_cyc[$];
    exp_t        mon_e;
    int          n_checks  = 0;
    int          n_err     = 0;
    int unsigned cyc       = 0;
    bit          check_lat = 1'b0;

    localparam logic signed [65:0] SMAX = 66'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0] SMIN = -66'sh8000_0000_0000_0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic, no slicing.
    function automatic exp_t ref_model(input word_t a, input word_t b, input logic c);
        exp_t                   r;
        logic [64:0]            wide;
        logic signed [65:0]     sa;
        logic signed [65:0]     sb;
        logic signed [65:0]     sd;
        wide    = {1'b0, a} - {1'b0, b} - {64'd0, c};
        r.diff  = wide[63:0];
        r.bout  = ({1'b0, a} < ({1'b0, b} + {64'd0, c}));
        sa      = 66'($signed(a));
        sb      = 66'($signed(b));
        sd      = sa - sb - $signed({65'd0, c});
        r.ovf   = (sd > SMAX) || (sd < SMIN);
        r.acc_cyc = 0;
        return r;
    endfunction

    function automatic word_t rand_word();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor / scoreboard: consume first, then record any new acceptance.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready_rule", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("out cyc=%0d diff=%h borrow=%0b ovf=%0b",
                             cyc, bus.diff_out, bus.borrow_out, bus.ovf_out);
                    chk("diff", bus.diff_out, mon_e.diff);
                    chk("borrow", 64'(bus.borrow_out), 64'(mon_e.bout));
                    chk("ovf", 64'(bus.ovf_out), 64'(mon_e.ovf));
                    if (check_lat)
                        chk("latency", 64'(cyc - mon_e.acc_cyc), 64'd4);
                    cons_cyc.push_back(cyc);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                mon_e = ref_model(bus.a_in, bus.b_in, bus.borrow_in);
                mon_e.acc_cyc = cyc;
                exp_q.push_back(mon_e);
            end
        end
    end

    // Drive one transfer; returns just after the edge that accepted it.
    task automatic send(input word_t a, input word_t b, input logic c);
        int n = 0;
        bus.in_valid  = 1'b1;
        bus.a_in      = a;
        bus.b_in      = b;
        bus.borrow_in = c;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) chk("send_in_ready_timeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic directed(input string tag, input word_t a, input word_t b, input logic c,
                            input word_t ed, input logic eb, input logic eo);
        int n = 0;
        check_lat = 1'b1;
        send(a, b, c);
        @(negedge clk);
        while (!bus.out_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_diff"}, bus.diff_out, ed);
        chk({tag, "_borrow"}, 64'(bus.borrow_out), 64'(eb));
        chk({tag, "_ovf"}, 64'(bus.ovf_out), 64'(eo));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t snap_d;
        logic  snap_b;
        logic  snap_o;
        bit    pend;

        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.borrow_in = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_diff", bus.diff_out, 64'd0);
        chk("rst_borrow", 64'(bus.borrow_out), 64'd0);
        chk("rst_ovf", 64'(bus.ovf_out), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed corners
        directed("d_5m3", 64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0);
        directed("d_0m1", 64'd0, 64'd1, 1'b0, '1, 1'b1, 1'b0);
        directed("d_min", 64'h8000_0000_0000_0000, 64'd1, 1'b0,
                 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        directed("d_bin", 64'd0, 64'd0, 1'b1, '1, 1'b1, 1'b0);
        directed("d_maxmneg", 64'h7FFF_FFFF_FFFF_FFFF, '1, 1'b0,
                 64'h8000_0000_0000_0000, 1'b1, 1'b1);

        // Back-to-back random transfers
        check_lat = 1'b1;
        cons_cyc.delete();
        for (int i = 0; i < 8; i++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        repeat (8) @(negedge clk);
        chk("b2b_count", 64'(cons_cyc.size()), 64'd8);
        if (cons_cyc.size() == 8)
            chk("b2b_consecutive", 64'(cons_cyc[7] - cons_cyc[0]), 64'd7);
        @(posedge clk);
        #1;

        // Fill pipe, then stall for 5 cycles with a fifth transfer waiting
        check_lat = 1'b0;
        bus.out_ready = 1'b0;
        cons_cyc.delete();
        for (int i = 0; i < 4; i++)
            send(rand_word(), rand_word(), 1'($urandom_range(0, 1)));
        snap_d = bus.diff_out;
        snap_b = bus.borrow_out;
        snap_o = bus.ovf_out;
        bus.in_valid  = 1'b1;
        bus.a_in      = rand_word();
        bus.b_in      = rand_word();
        bus.borrow_in = 1'($urandom_range(0, 1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_diff_frozen", bus.diff_out, snap_d);
            chk("stall_borrow_frozen", 64'(bus.borrow_out), 64'(snap_b));
            chk("stall_ovf_frozen", 64'(bus.ovf_out), 64'(snap_o));
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("stall_drain_count", 64'(cons_cyc.size()), 64'd5);
        @(posedge clk);
        #1;

        // Reset with three transfers in flight
        for (int i = 0; i < 3; i++)
            send(rand_word(), rand_word(), 1'($urandom_range(0, 1)));
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_reset_out_valid", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // Randomized valid/ready traffic
        pend = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend          = 1'b1;
                bus.a_in      = rand_word();
                bus.b_in      = rand_word();
                bus.borrow_in = 1'($urandom_range(0, 1));
            end
            bus.in_valid  = pend;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) pend = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("final_drain", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sub_64.md
SUB_64 -- requirements
Module: sub_64

Interface
REQ-001 Parameters SHALL be none; widths are fixed at 64-bit data, 16-bit slices, 4 stages.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  a_in/b_in/borrow_in carry a transfer this cycle.
REQ-005 in_ready  output  1  pipeline can accept a transfer this cycle.
REQ-006 a_in  input  64  minuend, unsigned.
REQ-007 b_in  input  64  subtrahend, unsigned.
REQ-008 borrow_in  input  1  borrow into bit 0.
REQ-009 out_valid  output  1  diff_out/borrow_out/ovf_out hold a result.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 diff_out  output  64  (a_in - b_in - borrow_in) mod 2^64.
REQ-012 borrow_out  output  1  1 when a_in < b_in + borrow_in (unsigned).
REQ-013 ovf_out  output  1  two's-complement overflow: a_in[63]!=b_in[63] and diff_out[63]!=a_in[63].

Function
REQ-014 A transfer SHALL be accepted when in_valid && in_ready; a result SHALL be consumed when out_valid && out_ready.
REQ-015 Stall condition SHALL be stall = out_valid && !out_ready; in_ready SHALL equal !stall combinationally.
REQ-016 During stall, every pipeline register (data, borrow, valid) SHALL hold its value; no transfer is lost or duplicated.
REQ-017 Without stall, stage k (k=0..3) SHALL compute slice bits [16k+15:16k] from skewed operand registers and stage k-1's registered borrow (stage 0 uses borrow_in directly).
REQ-018 Operand bits of slice k SHALL be delayed k register stages so they meet their borrow; finished low slices SHALL be delayed so all four slices emerge together.
REQ-019 Latency SHALL be exactly 4 cycles from acceptance to out_valid=1 when no stall occurs; throughput SHALL be one result per cycle.
REQ-020 Each stage SHALL carry a valid bit; a bubble (in_valid=0 while unstalled) SHALL propagate as out_valid=0 and SHALL NOT disturb neighbouring results.
REQ-021 borrow_out SHALL be the registered borrow from slice 3; ovf_out SHALL use the a/b sign bits carried with slice 3.
REQ-022 Results SHALL emerge in acceptance order.
REQ-023 A simultaneous consume and accept in a full pipeline SHALL advance all stages by one with no bubble.
REQ-024 diff_out/borrow_out/ovf_out SHALL be don't-care but stable while out_valid=0 and stalled.

Reset
REQ-025 When rst_n=0 at a rising edge, all valid bits, operand, partial-difference and borrow registers SHALL clear to 0.
REQ-026 After reset, out_valid=0, diff_out=0, borrow_out=0, ovf_out=0, and in_ready=1.
REQ-027 Reset mid-operation SHALL discard all in-flight transfers; no result from before reset SHALL appear afterwards.

Structure
REQ-028 A shared package SHALL hold DATA_W=64, SLICE_W=16, N_STAGES=4.
REQ-029 One sub-module sub_16 SHALL implement a combinational 16-bit slice: {borrow_out, diff} = a - b - borrow_in, instantiated four times.
REQ-030 Handshake/stall logic SHALL be a single global enable; no per-stage skid buffers.

Verification
REQ-031 Reset then a=0x0000_0000_0000_0005, b=3, borrow_in=0 -> 4 cycles later diff=2, borrow_out=0, ovf_out=0.
REQ-032 a=0, b=1, borrow_in=0 -> diff=0xFFFF_FFFF_FFFF_FFFF, borrow_out=1 (borrow ripples through all slices).
REQ-033 a=0x8000_0000_0000_0000, b=1 -> diff=0x7FFF_FFFF_FFFF_FFFF, ovf_out=1, borrow_out=0.
REQ-034 Back-to-back 8 random transfers, out_ready=1 -> 8 consecutive out_valid cycles, in order, matching reference model.
REQ-035 Fill pipeline, hold out_ready=0 for 5 cycles -> in_ready=0, outputs frozen; release -> all 4 results delivered in order, none lost.
REQ-036 rst_n=0 for one cycle with 3 transfers in flight -> out_valid=0 for next 4 cycles absent new input.
